// File: rtl/mux4_sel_arbiter_if.sv
// Handshake bundle between the request sources and the arbiter that steers the 4:1 mux.
// The arbiter uses the slave modport. The requesting side uses the master modport.
interface mux4_sel_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  modport master (output req, output done, input sel, input gnt, input valid, input timeout);
  modport slave  (input req, input done, output sel, output gnt, output valid, output timeout);
endinterface

// File: rtl/mux4_sel_arbiter.sv
// Four-source arbiter driving a 4:1 mux select, with a hold-timeout. Grant latency is 1 cycle, and all outputs are registered.
// It holds the grant until done, a dropped request, or MAX_HOLD cycles. Round-robin search is enabled with ARB4_ROUND_ROBIN_EN.
module mux4_sel_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux4_sel_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [1:0] start;
  logic [1:0] winner;
  logic       early_exit;
  logic       at_limit;

`ifdef ARB4_ROUND_ROBIN_EN
  logic [1:0] last_sel_q, last_sel_d;
`endif

  // Returns the first set bit found scanning upward from 'first' with wraparound.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] first);
    logic [1:0] idx;
    pick = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      idx = first + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

`ifdef ARB4_ROUND_ROBIN_EN
  assign start = last_sel_q + 2'd1;
`else
  assign start = 2'd0;
`endif

  assign winner     = pick(bus.req, start);
  assign early_exit = bus.done || !bus.req[sel_q];
  assign at_limit   = (cnt_q == HOLD_LIM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    gnt_d     = 4'b0000;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef ARB4_ROUND_ROBIN_EN
    last_sel_d = last_sel_q;
`endif
    case (state_q)
      GRANT: begin
        cnt_d = cnt_q + 8'd1;
        if (early_exit || at_limit) begin
          state_d   = RELEASE;
          timeout_d = at_limit && !early_exit;
        end else begin
          valid_d = 1'b1;
          gnt_d   = gnt_q;
        end
      end
      default: begin
        // IDLE and RELEASE arbitrate identically.
        if (|bus.req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
`ifdef ARB4_ROUND_ROBIN_EN
          last_sel_d = winner;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      sel_q     <= 2'b00;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB4_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_sel_q <= 2'b11;
    else        last_sel_q <= last_sel_d;
  end
`endif

  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/mux4_sel_arbiter.md
# mux4_sel_arbiter

Four-requester arbiter that drives the 2-bit select and grant signals of the downstream 4:1 priority multiplexer. It accepts request lines from four sources, grants exactly one at a time, and holds the select stable for the life of the grant. A hold-timeout stops any source from monopolising the mux. It sits directly upstream of the mux: `sel` connects straight to the mux select, and `valid` qualifies the mux output.

## Interface
- `MAX_HOLD`, default 15: maximum number of cycles a grant may stay asserted. Legal range is 1..255.
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  4  request lines. `req[0]` is source 0.
- `done`  input  1  the granted source finished; release the grant.
- `sel`  output  2  mux select, the index of the granted or last-granted source.
- `gnt`  output  4  one-hot grant, or all zeros.
- `valid`  output  1  a grant is active and the mux output is meaningful.
- `timeout`  output  1  one-cycle pulse when a grant is force-released.

## Operation
- Reset values: `sel`=2'b00, `gnt`=4'b0000, `valid`=0, `timeout`=0. Internal state after reset:
  - state = IDLE
  - hold counter = 0
  - `last_sel`=2'b11
- The reset is asynchronous. Asserting it mid-grant drops all outputs immediately, with no RELEASE cycle.
- **IDLE:**
  - `valid`=0, `gnt`=0, `sel` holds its last value.
  - If any `req` bit is set, pick a winner, load `sel`/`gnt`/`last_sel`, clear the counter, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - `valid`=1, `gnt`=onehot(`sel`). The counter increments every cycle.
  - Exit to RELEASE when any of these holds at a sampled edge:
    - `done`=1
    - `req[sel]`=0 (the source dropped its request)
    - the counter equals `MAX_HOLD`-1
  - `timeout` is pulsed in the first RELEASE cycle only when the exit cause is the counter alone. If `done` or a dropped request coincides with the counter limit, there is no pulse.
- **RELEASE:**
  - `valid`=0, `gnt`=0, `sel` is held.
  - Arbitrates exactly as IDLE does: go to GRANT with a new winner if any `req` bit is set, else go to IDLE.
  - This guarantees one dead cycle between consecutive grants.
- **Winner selection, fixed priority:** the lowest-index set bit wins (`req[0]` highest).
- While in GRANT, new or changed requests from other sources are ignored. No preemption.
- `sel` never changes while `valid`=1.
- Counter width is 8 bits. `MAX_HOLD`=1 yields a one-cycle grant, and the timeout pulse fires unless `done` is high or the request drops in that cycle.

## Timing
- Grant latency:
  - `req` sampled high at edge k in IDLE/RELEASE.
  - `gnt`, `sel` and `valid` are valid after edge k, in cycle k+1.
- Release:
  - `done` sampled high at edge m.
  - `valid`/`gnt` are low after edge m, in cycle m+1.
- Timeout:
  - `valid` is high for exactly `MAX_HOLD` cycles.
  - `timeout` is high for exactly one cycle, coincident with the RELEASE cycle.
- Back-to-back throughput: at best one grant every G+1 cycles, where G is the grant length.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ARB4_ROUND_ROBIN_EN` defined:
  - The winner search starts at (`last_sel`+1) mod 4 and wraps around.
  - `last_sel` updates on every grant.
  - The first grant after reset searches from index 0.
- `ARB4_ROUND_ROBIN_EN` undefined:
  - Fixed priority as described in Operation.
  - `last_sel` is unused and may be optimised away.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Reset:** assert `rst_n` low mid-GRANT with `sel`=2'b10 → all outputs go to reset values asynchronously, before the next edge. After release with `req`=0, the block stays in IDLE.
- **Fixed-priority grant:** `req`=4'b1010 in IDLE → next cycle `gnt`=4'b0010, `sel`=2'b01, `valid`=1. Then `done` high for 1 cycle after 3 grant cycles → `valid` low the next cycle.
- **Timeout:** `MAX_HOLD`=4, `req`=4'b0100 held, `done`=0 →
  - `valid` high for exactly 4 cycles,
  - `timeout`=1 for 1 cycle with `valid`=0,
  - then a re-grant with `sel`=2'b10.
- **Done at the limit:** `MAX_HOLD`=4, `done`=1 on the 4th grant cycle → release with `timeout`=0.
- **Dropped request:** `req[1]` deasserted mid-grant → `valid` low next cycle. `req[3]` pending → granted after a single dead cycle, `sel`=2'b11.
- **Fairness:** `req`=4'b1111 held, `done` on every grant's first cycle →
  - round-robin build: `sel` sequence 00,01,10,11,00
  - fixed build: 00,00,00,00,00
